ucaspian_axon: RTL and testbench
================================

Name: ucaspian_axon

Overview:
- Sits directly upstream of the synapse unit. Accepts fire events from the neuron stage, one neuron id per event, and queues them in a small FIFO.
- For each fire, looks up the neuron's outgoing synapse range (start address and count) in a 256-entry axon table.
- Streams the synapse addresses start .. start+count-1 to the synapse unit over a valid/ready handshake.
- Reports step completion and supports activity clear and configuration clear.

Parameters:
- FIFO_DEPTH, 16, fire-event queue depth in entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active-low
- enable  in  1  allow new fire events to be popped and processed
- clear_act  in  1  flush pending activity
- clear_config  in  1  zero the axon table
- clear_done  out  1  clear complete
- step_done  out  1  block idle, no pending work
- cfg_addr  in  8  neuron id for config write
- cfg_value  in  8  config byte
- cfg_byte  in  3  config byte index
- cfg_enable  in  1  config write strobe
- fire_addr  in  8  neuron id that fired
- fire_vld  in  1  fire valid
- fire_rdy  out  1  fire ready
- syn_addr  out  10  synapse address to synapse unit
- syn_vld  out  1  synapse address valid
- syn_rdy  in  1  synapse unit ready

Behaviour:
- Reset (reset_n low, asynchronous):
  - Outputs: syn_vld=0, syn_addr=0, fire_rdy=0, step_done=0, clear_done=0.
  - FIFO empty, state IDLE, cfg latches cleared.
  - Table contents are not reset.
  - Reset asserted mid-emission aborts the emission immediately; the dropped events are not replayed.
- Axon table: 256 x 18 bits, entry = {start[9:0], count[7:0]}. Read is registered (1-cycle latency). Configuration writes happen only while cfg_enable=1 and clear_config=0:
  - cfg_byte 4: latch cfg_value[1:0] as start[9:8].
  - cfg_byte 5: latch cfg_value as start[7:0].
  - cfg_byte 6: write {latched start, cfg_value} to entry cfg_addr.
  - All other cfg_byte values: ignored.
- FIFO and fire handshake:
  - fire_rdy = !full && !clear_act && !clear_config (registered, reset 0).
  - A push occurs on fire_vld && fire_rdy.
  - When full, fire_rdy is low even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: occupancy unchanged.
  - Pointer wrap is modulo FIFO_DEPTH.
- State machine:
  - IDLE: if the FIFO is non-empty and enable=1 and cfg_enable=0, pop the head, issue the table read, and go to LOOKUP.
  - LOOKUP: capture the entry.
    - count==0: go to IDLE with no output.
    - Otherwise: syn_addr<=start, syn_vld<=1, remaining<=count, go to EMIT.
  - EMIT: on syn_vld && syn_rdy, decrement remaining.
    - If remaining>1: syn_addr<=syn_addr+1 (mod 1024, so 1023 wraps to 0) and syn_vld stays 1.
    - On the last handshake: syn_vld<=0, then the next state is LOOKUP with a new pop if the FIFO is non-empty and enable=1 and cfg_enable=0, otherwise IDLE.
    - syn_addr and syn_vld hold stable while syn_rdy=0.
  - A run in progress completes even if enable falls mid-run.
  - CLEAR: entered from any state on clear_config; walks entries 0..255 writing zero, one entry per cycle.
- Latency:
  - Fire accepted on edge N with FIFO empty and state IDLE: pop occurs on edge N+1 and syn_vld=1 after edge N+2.
  - With syn_rdy held high: one address per cycle.
  - Between runs: one bubble cycle (LOOKUP).
- clear_act: syn_vld<=0, FIFO flushed, state IDLE, clear_done<=1 while clear_act is held.
- clear_config: clear_done<=1 only after entry 255 is written, held until clear_config drops. The walk restarts from 0 on each new assertion.
- step_done: 1 when state is IDLE, FIFO empty, syn_vld=0, and no clear in progress; otherwise 0.

Test Plan:
- Config neuron 3 = {start=100, count=4}, fire 3, syn_rdy=1 -> syn_addr 100,101,102,103 on consecutive cycles; syn_vld rises 2 clocks after acceptance; step_done returns to 1.
- Config neuron 7 = {start=1022, count=3}, fire 7 -> syn_addr 1022,1023,0.
- syn_rdy toggled 1,0,0,1,... during a count=5 run -> syn_addr and syn_vld held while syn_rdy=0; exactly 5 handshakes, no duplicates.
- Push 17 fires with enable=0 -> fire_rdy low after 16 accepts; raise enable -> all 16 runs emitted in FIFO order, each run separated by one bubble; count=0 entries produce no output.
- clear_act mid-run with 3 fires queued -> syn_vld=0 the next cycle, FIFO empty, clear_done=1; no further syn_vld after release.
- clear_config held -> clear_done after 256 cycles; every neuron then has count 0. reset_n pulsed low mid-run -> syn_vld=0 immediately and no output after release.

Source files
------------

// File: rtl/ucaspian_axon.sv
// Axon stage: queues neuron fire events, looks up each neuron's synapse range
// in a 256-entry table and streams the synapse addresses to the synapse unit.
module ucaspian_axon #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       clear_act,
    input  logic       clear_config,
    output logic       clear_done,
    output logic       step_done,
    input  logic [7:0] cfg_addr,
    input  logic [7:0] cfg_value,
    input  logic [2:0] cfg_byte,
    input  logic       cfg_enable,
    input  logic [7:0] fire_addr,
    input  logic       fire_vld,
    output logic       fire_rdy,
    output logic [9:0] syn_addr,
    output logic       syn_vld,
    input  logic       syn_rdy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOOKUP, EMIT, CLEAR} state_t;

    state_t           state, state_nx;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx;
    logic [PTR_W:0]   count, count_nx;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [17:0]      axon_mem [256];
    logic [17:0]      entry_p1;
    logic [1:0]       start_hi;
    logic [7:0]       start_lo;
    logic [7:0]       remaining, remaining_nx;
    logic [7:0]       clr_idx, clr_idx_nx;
    logic [9:0]       syn_addr_nx;
    logic             syn_vld_nx, clear_done_nx, fire_rdy_nx, step_done_nx;
    logic             push, pop, flush, can_start;
    logic             tbl_we;
    logic [7:0]       tbl_waddr;
    logic [17:0]      tbl_wdata;

    assign push      = fire_vld && fire_rdy;
    assign can_start = (count != '0) && enable && !cfg_enable;

    always_comb begin
        state_nx      = state;
        syn_addr_nx   = syn_addr;
        syn_vld_nx    = syn_vld;
        remaining_nx  = remaining;
        clr_idx_nx    = clr_idx;
        clear_done_nx = 1'b0;
        pop           = 1'b0;
        flush         = 1'b0;
        tbl_we        = 1'b0;
        tbl_waddr     = cfg_addr;
        tbl_wdata     = {start_hi, start_lo, cfg_value};

        if (clear_config) begin
            syn_vld_nx = 1'b0;
            tbl_wdata  = '0;
            if (state != CLEAR) begin
                // Entry 0 is zeroed on the entering edge so the walk takes 256 cycles.
                state_nx   = CLEAR;
                tbl_we     = 1'b1;
                tbl_waddr  = 8'd0;
                clr_idx_nx = 8'd1;
            end else if (!clear_done) begin
                tbl_we        = 1'b1;
                tbl_waddr     = clr_idx;
                clr_idx_nx    = clr_idx + 8'd1;
                clear_done_nx = (clr_idx == 8'd255);
            end else begin
                clear_done_nx = 1'b1;
            end
        end else if (clear_act) begin
            syn_vld_nx    = 1'b0;
            flush         = 1'b1;
            state_nx      = IDLE;
            clear_done_nx = 1'b1;
        end else begin
            tbl_we = cfg_enable && (cfg_byte == 3'd6);
            case (state)
                IDLE: begin
                    if (can_start) begin
                        pop      = 1'b1;
                        state_nx = LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (entry_p1[7:0] == 8'd0) begin
                        state_nx = IDLE;
                    end else begin
                        syn_addr_nx  = entry_p1[17:8];
                        syn_vld_nx   = 1'b1;
                        remaining_nx = entry_p1[7:0];
                        state_nx     = EMIT;
                    end
                end
                EMIT: begin
                    if (syn_vld && syn_rdy) begin
                        remaining_nx = remaining - 8'd1;
                        if (remaining > 8'd1) begin
                            syn_addr_nx = syn_addr + 10'd1;
                        end else begin
                            syn_vld_nx = 1'b0;
                            if (can_start) begin
                                pop      = 1'b1;
                                state_nx = LOOKUP;
                            end else begin
                                state_nx = IDLE;
                            end
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        if (flush) begin
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
            count_nx  = '0;
        end else begin
            wr_ptr_nx = wr_ptr + PTR_W'(push);
            rd_ptr_nx = rd_ptr + PTR_W'(pop);
            count_nx  = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end

        fire_rdy_nx  = (count_nx != FULL_CNT) && !clear_act && !clear_config;
        step_done_nx = (state_nx == IDLE) && (count_nx == '0) && !syn_vld_nx
                       && !clear_act && !clear_config;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            syn_addr   <= '0;
            syn_vld    <= 1'b0;
            remaining  <= '0;
            clr_idx    <= '0;
            clear_done <= 1'b0;
            fire_rdy   <= 1'b0;
            step_done  <= 1'b0;
            start_hi   <= '0;
            start_lo   <= '0;
        end else begin
            state      <= state_nx;
            wr_ptr     <= wr_ptr_nx;
            rd_ptr     <= rd_ptr_nx;
            count      <= count_nx;
            syn_addr   <= syn_addr_nx;
            syn_vld    <= syn_vld_nx;
            remaining  <= remaining_nx;
            clr_idx    <= clr_idx_nx;
            clear_done <= clear_done_nx;
            fire_rdy   <= fire_rdy_nx;
            step_done  <= step_done_nx;
            if (cfg_enable && !clear_config) begin
                if (cfg_byte == 3'd4) start_hi <= cfg_value[1:0];
                if (cfg_byte == 3'd5) start_lo <= cfg_value;
            end
        end
    end

    // Storage arrays and the registered table read carry no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= fire_addr;
        if (tbl_we) axon_mem[tbl_waddr] <= tbl_wdata;
        if (pop) entry_p1 <= axon_mem[fifo_mem[rd_ptr]];
    end
endmodule

// File: tb/tb_ucaspian_axon.sv
// Scoreboard bench for ucaspian_axon: expected synapse addresses are queued
// at fire acceptance and compared on every syn_vld/syn_rdy handshake.
module tb_ucaspian_axon;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       clear_act = 1'b0;
    logic       clear_config = 1'b0;
    logic       clear_done, step_done;
    logic [7:0] cfg_addr = '0;
    logic [7:0] cfg_value = '0;
    logic [2:0] cfg_byte = '0;
    logic       cfg_enable = 1'b0;
    logic [7:0] fire_addr = '0;
    logic       fire_vld = 1'b0;
    logic       fire_rdy;
    logic [9:0] syn_addr;
    logic       syn_vld;
    logic       syn_rdy = 1'b0;

    ucaspian_axon #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear_act(clear_act),
        .clear_config(clear_config), .clear_done(clear_done), .step_done(step_done),
        .cfg_addr(cfg_addr), .cfg_value(cfg_value), .cfg_byte(cfg_byte),
        .cfg_enable(cfg_enable), .fire_addr(fire_addr), .fire_vld(fire_vld),
        .fire_rdy(fire_rdy), .syn_addr(syn_addr), .syn_vld(syn_vld), .syn_rdy(syn_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    logic [9:0] exp_q[$];
    int gap_q[$];
    logic gap_en = 1'b0;
    int gap_cnt = 0;
    logic in_run = 1'b0, seen_run = 1'b0;
    logic [9:0] m_start [256];
    logic [7:0] m_cnt [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (syn_vld && syn_rdy) begin
            hs_count++;
            if (exp_q.size() == 0) chk("extra_out", 32'(syn_addr), 32'h7fff_ffff);
            else chk("syn_addr", 32'(syn_addr), 32'(exp_q.pop_front()));
        end
        if (!gap_en) begin
            in_run = 1'b0; seen_run = 1'b0; gap_cnt = 0;
        end else if (syn_vld) begin
            if (!in_run && seen_run) begin
                if (gap_q.size() == 0) chk("gap_extra", gap_cnt, 0);
                else chk("gap", gap_cnt, gap_q.pop_front());
            end
            in_run = 1'b1; seen_run = 1'b1; gap_cnt = 0;
        end else begin
            in_run = 1'b0;
            gap_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] id, input logic [9:0] start, input logic [7:0] cnt);
        cfg_enable = 1'b1; cfg_addr = id;
        cfg_byte = 3'd4; cfg_value = {6'd0, start[9:8]}; tick();
        cfg_byte = 3'd5; cfg_value = start[7:0]; tick();
        cfg_byte = 3'd6; cfg_value = cnt; tick();
        cfg_enable = 1'b0; cfg_byte = 3'd0;
        m_start[id] = start; m_cnt[id] = cnt;
    endtask

    task automatic fire(input logic [7:0] id);
        logic [9:0] a;
        int n = 0;
        while (!fire_rdy && n < 100) begin tick(); n++; end
        if (!fire_rdy) begin
            chk("fire_rdy_timeout", 0, 1);
            return;
        end
        fire_addr = id; fire_vld = 1'b1;
        @(posedge clk);
        for (int k = 0; k < int'(m_cnt[id]); k++) begin
            a = m_start[id] + 10'(k);
            exp_q.push_back(a);
        end
        #1 fire_vld = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (!(step_done && exp_q.size() == 0) && n < bound) begin tick(); n++; end
        chk("idle_reached", 32'(step_done && exp_q.size() == 0), 1);
    endtask

    task automatic wait_vld(input int bound);
        int n = 0;
        while (!syn_vld && n < bound) begin tick(); n++; end
        chk("vld_seen", 32'(syn_vld), 1);
    endtask

    initial begin
        int hs0, z, n;
        logic pv, pr, have_prev;
        logic [9:0] pa;
        logic [7:0] id;

        #2 reset_n = 1'b0;
        tick(); tick();
        chk("rst_syn_vld", 32'(syn_vld), 0);
        chk("rst_syn_addr", 32'(syn_addr), 0);
        chk("rst_fire_rdy", 32'(fire_rdy), 0);
        chk("rst_step_done", 32'(step_done), 0);
        chk("rst_clear_done", 32'(clear_done), 0);
        reset_n = 1'b1;
        tick(); tick();
        chk("post_rst_fire_rdy", 32'(fire_rdy), 1);
        chk("post_rst_step_done", 32'(step_done), 1);

        // Basic run and latency
        cfg_write(8'd3, 10'd100, 8'd4);
        enable = 1'b1; syn_rdy = 1'b1;
        fire(8'd3);
        chk("lat_n0_vld", 32'(syn_vld), 0);
        tick();
        chk("lat_n1_vld", 32'(syn_vld), 0);
        tick();
        chk("lat_n2_vld", 32'(syn_vld), 1);
        tick(); tick(); tick();
        chk("run_last_addr", 32'(syn_addr), 103);
        chk("run_last_vld", 32'(syn_vld), 1);
        tick();
        chk("run_end_vld", 32'(syn_vld), 0);
        wait_idle(20);

        // Wrap past address 1023
        cfg_write(8'd7, 10'd1022, 8'd3);
        fire(8'd7);
        wait_idle(30);

        // Backpressure on syn_rdy
        cfg_write(8'd9, 10'd200, 8'd5);
        hs0 = hs_count;
        fire(8'd9);
        for (int i = 0; i < 30; i++) begin
            syn_rdy = (i % 4 == 0) || (i % 4 == 3);
            pv = syn_vld; pa = syn_addr; pr = syn_rdy;
            tick();
            if (pv && !pr) begin
                chk("hold_vld", 32'(syn_vld), 1);
                chk("hold_addr", 32'(syn_addr), 32'(pa));
            end
        end
        syn_rdy = 1'b1;
        chk("bp_handshakes", hs_count - hs0, 5);
        wait_idle(30);

        // Fill FIFO with enable low, then drain in order
        for (int i = 0; i < 17; i++)
            cfg_write(8'(20 + i), 10'(300 + i * 8), (i % 4 == 2) ? 8'd0 : 8'((i % 3) + 1));
        enable = 1'b0;
        z = 0; have_prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            id = 8'(20 + i);
            fire(id);
            if (m_cnt[id] == 8'd0) z++;
            else begin
                if (have_prev) gap_q.push_back(1 + 2 * z);
                z = 0; have_prev = 1'b1;
            end
        end
        tick();
        chk("full_fire_rdy", 32'(fire_rdy), 0);
        fire_addr = 8'd36; fire_vld = 1'b1;
        tick(); tick(); tick();
        chk("full_still_blocked", 32'(fire_rdy), 0);
        fire_vld = 1'b0;
        gap_en = 1'b1; enable = 1'b1;
        wait_idle(400);
        gap_en = 1'b0;
        chk("gaps_consumed", gap_q.size(), 0);

        // clear_act mid-run
        cfg_write(8'd40, 10'd500, 8'd20);
        fire(8'd40);
        wait_vld(10);
        tick(); tick();
        fire(8'd3); fire(8'd7); fire(8'd9);
        clear_act = 1'b1; syn_rdy = 1'b0;
        tick();
        chk("ca_syn_vld", 32'(syn_vld), 0);
        chk("ca_clear_done", 32'(clear_done), 1);
        tick();
        chk("ca_fire_rdy", 32'(fire_rdy), 0);
        chk("ca_clear_done_held", 32'(clear_done), 1);
        clear_act = 1'b0;
        exp_q.delete();
        syn_rdy = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk("ca_after_step_done", 32'(step_done), 1);
        chk("ca_after_clear_done", 32'(clear_done), 0);

        // clear_config walk
        clear_config = 1'b1;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (clear_done) begin n = i; break; end
        end
        chk("cc_cycles", n, 256);
        tick();
        chk("cc_done_held", 32'(clear_done), 1);
        clear_config = 1'b0;
        for (int i = 0; i < 256; i++) m_cnt[i] = 8'd0;
        tick(); tick();
        chk("cc_done_released", 32'(clear_done), 0);
        fire(8'd3); fire(8'd7); fire(8'd9); fire(8'd40);
        for (int i = 0; i < 20; i++) tick();
        chk("cc_no_output_idle", 32'(step_done), 1);

        // Asynchronous reset mid-run
        cfg_write(8'd50, 10'd600, 8'd30);
        fire(8'd50);
        wait_vld(10);
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("ar_syn_vld", 32'(syn_vld), 0);
        chk("ar_syn_addr", 32'(syn_addr), 0);
        chk("ar_fire_rdy", 32'(fire_rdy), 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        chk("ar_after_step_done", 32'(step_done), 1);
        chk("ar_after_fire_rdy", 32'(fire_rdy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
